delay_line_ctrl: RTL and testbench
==================================

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 SHALL have parameter MAX_DELAY_CLK, default 100, largest programmable delay in clocks.
REQ-002 SHALL have parameter FLUSH_CLK, default 4, delay-line reset pulse length in clocks (min 1).
REQ-003 SHALL have parameter TIMEOUT_MARGIN, default 16, extra clocks allowed for fill beyond the programmed delay.
REQ-004 SHALL define CNT_W = ceil-log2 of MAX_DELAY_CLK, computed as number of bits to represent MAX_DELAY_CLK (7 for 100).
REQ-005 SHALL have ports, clock and reset first; reset RESETN, synchronous, active-low; clock CLK:
 CLK  in  1  clock
 RESETN  in  1  sync active-low reset
 CFG_DELAY  in  CNT_W  requested delay
 CFG_VALID  in  1  request valid
 CFG_READY  out  1  request accepted when VALID&READY
 DL_RESETN  out  1  local reset to delay line
 DL_DELAY_CLK  out  CNT_W  delay value to delay line
 DL_READY  in  1  delay-line write enable status
 DL_VALID  in  1  delay-line output valid
 BUSY  out  1  reconfiguration in progress
 LOCKED  out  1  delay line running at CUR_DELAY
 CUR_DELAY  out  CNT_W  delay of last accepted request (post-clamp)
 ERR  out  2  [0] clamp, [1] fill timeout; sticky

Function
REQ-006 SHALL implement FSM states IDLE, FLUSH, FILL, RUN.
REQ-007 SHALL assert CFG_READY combinationally only in IDLE and RUN.
REQ-008 SHALL, on handshake in cycle t, latch min(CFG_DELAY, MAX_DELAY_CLK) into CUR_DELAY/DL_DELAY_CLK at t+1, clear ERR, enter FLUSH at t+1.
REQ-009 SHALL set ERR[0] at t+1 when CFG_DELAY > MAX_DELAY_CLK.
REQ-010 SHALL drive DL_RESETN low in IDLE and for exactly FLUSH_CLK cycles in FLUSH, holding DL_DELAY_CLK stable throughout.
REQ-011 SHALL enter FILL after FLUSH_CLK cycles, DL_RESETN high, fill counter cleared.
REQ-012 SHALL go FILL->RUN the cycle after DL_VALID sampled high; LOCKED=1 exactly in RUN.
REQ-013 SHALL assert BUSY exactly in FLUSH and FILL.
REQ-014 SHALL ignore DL_READY and DL_VALID for state changes in RUN; loss of DL_VALID does not drop LOCKED.
REQ-015 SHALL, on a new handshake in RUN, drop LOCKED at t+1 and restart at FLUSH.
REQ-016 SHALL ignore CFG_VALID in FLUSH and FILL; no request queued.
REQ-017 SHALL, at delay 0, still perform full FLUSH and FILL.

Reset
REQ-018 SHALL on RESETN low: state IDLE, DL_RESETN=0, DL_DELAY_CLK=0, CUR_DELAY=0, BUSY=0, LOCKED=0, ERR=0; CFG_READY=1 the cycle after release.
REQ-019 SHALL abort any in-progress FLUSH/FILL on RESETN mid-operation, with no residual counter state.

Configuration
REQ-020 SHALL, with DELAY_LINE_CTRL_TIMEOUT_EN defined, count FILL cycles; at CUR_DELAY+FLUSH_CLK+TIMEOUT_MARGIN without DL_VALID set ERR[1] and enter IDLE.
REQ-021 SHALL, without DELAY_LINE_CTRL_TIMEOUT_EN, wait in FILL indefinitely, tie ERR[1] to 0, omit the timeout counter.

Structure
REQ-022 SHALL place the state enum, ERR bit indices (ERR_CLAMP=0, ERR_TIMEOUT=1) and the clogb2 function in shared package delay_ctrl_pkg.
REQ-023 SHALL be one module, no sub-module; the delay line is instantiated by the parent beside it.

Verification
REQ-024 SHALL cover: reset, CFG_DELAY=10 handshake -> DL_RESETN low 4 cycles, DL_DELAY_CLK=10, LOCKED 1 cycle after DL_VALID.
REQ-025 SHALL cover: CFG_DELAY=120 -> CUR_DELAY=100, ERR=2'b01.
REQ-026 SHALL cover: in RUN at delay 10, request 30 -> LOCKED=0 next cycle, FLUSH, relock with DL_DELAY_CLK=30, ERR cleared.
REQ-027 SHALL cover: CFG_VALID held during FLUSH/FILL -> CFG_READY=0, accepted only on reaching RUN.
REQ-028 SHALL cover (macro on): delay 10, DL_VALID never high -> ERR=2'b10 and IDLE 30 cycles after FILL entry; macro off -> FILL persists, ERR=0.
REQ-029 SHALL cover: RESETN low for 1 cycle mid-FILL -> all outputs at reset values, CFG_READY=1 afterwards.

Source files
------------

// File: rtl/delay_ctrl_pkg.sv
// Shared types, error bit indices and width helper for the delay-line controller.
package delay_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2,
        ST_RUN   = 2'd3
    } dl_state_t;

    localparam int ERR_CLAMP   = 0;
    localparam int ERR_TIMEOUT = 1;

    // Number of bits needed to represent value (at least 1).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        if (v <= 0) return 1;
        while (v > 0) begin
            n++;
            v = v >>> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/delay_line_ctrl.sv
// Reconfigures an external delay line: flush, wait for fill, then report lock.
// Optional fill timeout enabled by defining DELAY_LINE_CTRL_TIMEOUT_EN.
module delay_line_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int MAX_DELAY_CLK  = 100,
    parameter int FLUSH_CLK      = 4,
    parameter int TIMEOUT_MARGIN = 16,
    localparam int CNT_W         = clogb2(MAX_DELAY_CLK)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [CNT_W-1:0] CFG_DELAY,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    output logic             DL_RESETN,
    output logic [CNT_W-1:0] DL_DELAY_CLK,
    input  logic             DL_READY,
    input  logic             DL_VALID,
    output logic             BUSY,
    output logic             LOCKED,
    output logic [CNT_W-1:0] CUR_DELAY,
    output logic [1:0]       ERR
);

    localparam int FL_W = clogb2(FLUSH_CLK);

    dl_state_t        state, state_nxt;
    logic [CNT_W-1:0] cur_delay;
    logic [FL_W-1:0]  flush_cnt;
    logic             clamp_err;
    logic             hs;
    logic             clamp;
    logic             flush_last;
    logic             unused_inputs;

    // DL_READY is status only; state changes never depend on it.
    assign unused_inputs = DL_READY;

    assign CFG_READY  = (state == ST_IDLE) || (state == ST_RUN);
    assign DL_RESETN  = (state == ST_FILL) || (state == ST_RUN);
    assign BUSY       = (state == ST_FLUSH) || (state == ST_FILL);
    assign LOCKED     = (state == ST_RUN);
    assign DL_DELAY_CLK = cur_delay;
    assign CUR_DELAY    = cur_delay;

    assign hs         = CFG_READY && CFG_VALID;
    assign clamp      = CFG_DELAY > CNT_W'(MAX_DELAY_CLK);
    assign flush_last = flush_cnt == FL_W'(FLUSH_CLK - 1);

`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
    localparam int TO_W = clogb2(MAX_DELAY_CLK + FLUSH_CLK + TIMEOUT_MARGIN);

    logic [TO_W-1:0] fill_cnt;
    logic [TO_W-1:0] fill_last_val;
    logic            fill_last;
    logic            timeout_err;

    // Give up on the last FILL cycle of delay + flush + margin.
    assign fill_last_val = TO_W'(cur_delay) + TO_W'(FLUSH_CLK + TIMEOUT_MARGIN - 1);
    assign fill_last     = (state == ST_FILL) && !DL_VALID && (fill_cnt == fill_last_val);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RUN: if (hs) state_nxt = ST_FLUSH;
            ST_FLUSH:        if (flush_last) state_nxt = ST_FILL;
            ST_FILL: begin
                if (DL_VALID) state_nxt = ST_RUN;
`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
                else if (fill_last) state_nxt = ST_IDLE;
`endif
            end
            default:         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state     <= ST_IDLE;
            cur_delay <= '0;
            clamp_err <= 1'b0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FL_W'(1) : '0;
            if (hs) begin
                cur_delay <= clamp ? CNT_W'(MAX_DELAY_CLK) : CFG_DELAY;
                clamp_err <= clamp;
            end
        end
    end

`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            fill_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            fill_cnt <= (state == ST_FILL) ? fill_cnt + TO_W'(1) : '0;
            if (hs)             timeout_err <= 1'b0;
            else if (fill_last) timeout_err <= 1'b1;
        end
    end
`endif

    always_comb begin
        ERR            = '0;
        ERR[ERR_CLAMP] = clamp_err;
`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
        ERR[ERR_TIMEOUT] = timeout_err;
`endif
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl: timestamp-based model checked every cycle plus literal spot checks.
module tb_delay_line_ctrl;

    localparam int MAXD = 100;
    localparam int FL   = 4;
    localparam int MARG = 16;
    localparam int W    = 7;

    localparam int P_IDLE  = 0;
    localparam int P_FLUSH = 1;
    localparam int P_FILL  = 2;
    localparam int P_RUN   = 3;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic [W-1:0] CFG_DELAY = '0;
    logic         CFG_VALID = 1'b0;
    logic         CFG_READY;
    logic         DL_RESETN;
    logic [W-1:0] DL_DELAY_CLK;
    logic         DL_READY = 1'b1;
    logic         DL_VALID = 1'b0;
    logic         BUSY;
    logic         LOCKED;
    logic [W-1:0] CUR_DELAY;
    logic [1:0]   ERR;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    delay_line_ctrl #(
        .MAX_DELAY_CLK (MAXD),
        .FLUSH_CLK     (FL),
        .TIMEOUT_MARGIN(MARG)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .CFG_DELAY   (CFG_DELAY),
        .CFG_VALID   (CFG_VALID),
        .CFG_READY   (CFG_READY),
        .DL_RESETN   (DL_RESETN),
        .DL_DELAY_CLK(DL_DELAY_CLK),
        .DL_READY    (DL_READY),
        .DL_VALID    (DL_VALID),
        .BUSY        (BUSY),
        .LOCKED      (LOCKED),
        .CUR_DELAY   (CUR_DELAY),
        .ERR         (ERR)
    );

    // Model: remembers when the last request was taken, when lock or timeout happened.
    bit           m_have = 0;
    int           m_e0   = 0;
    int           m_lock = 0;
    int           m_to   = 0;
    logic [W-1:0] m_delay = '0;
    logic [1:0]   m_err   = '0;

    function automatic int phase(input int n);
        if (!m_have)            return P_IDLE;
        if (m_lock != 0)        return P_RUN;
        if (m_to != 0)          return P_IDLE;
        if (n - m_e0 < FL)      return P_FLUSH;
        return P_FILL;
    endfunction

    always @(posedge CLK) begin
        int p;
        p = phase(cyc);
        cyc++;
        if (!RESETN) begin
            m_have = 0; m_delay = '0; m_err = '0; m_lock = 0; m_to = 0;
        end else if ((p == P_IDLE || p == P_RUN) && CFG_VALID) begin
            m_have  = 1;
            m_e0    = cyc;
            m_lock  = 0;
            m_to    = 0;
            m_delay = (int'(CFG_DELAY) > MAXD) ? W'(MAXD) : CFG_DELAY;
            m_err   = (int'(CFG_DELAY) > MAXD) ? 2'b01 : 2'b00;
        end else if (p == P_FILL) begin
            if (DL_VALID) m_lock = cyc;
`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
            else if (cyc - (m_e0 + FL) == int'(m_delay) + FL + MARG) begin
                m_to     = cyc;
                m_err[1] = 1'b1;
            end
`endif
        end
    end

    always @(negedge CLK) begin
        int p;
        logic [19:0] exp_v, act_v;
        if (cyc > 0) begin
            p = phase(cyc);
            exp_v = {p == P_IDLE || p == P_RUN, p == P_FILL || p == P_RUN,
                     p == P_FLUSH || p == P_FILL, p == P_RUN, m_delay, m_delay, m_err};
            act_v = {CFG_READY, DL_RESETN, BUSY, LOCKED, CUR_DELAY, DL_DELAY_CLK, ERR};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle%0d outputs {rdy,dlrst,busy,lock,cur,dl,err}: got %h expected %h",
                         cyc, act_v, exp_v);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic hs(input int d);
        CFG_DELAY = W'(d);
        CFG_VALID = 1'b1;
        step();
        CFG_VALID = 1'b0;
    endtask

    task automatic relock();
        repeat (FL + 2) step();
        DL_VALID = 1'b1;
        step();
        DL_VALID = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dl_resetn"}, 32'(DL_RESETN), 0);
        chk({tag, "_dl_delay"},  32'(DL_DELAY_CLK), 0);
        chk({tag, "_cur_delay"}, 32'(CUR_DELAY), 0);
        chk({tag, "_busy"},      32'(BUSY), 0);
        chk({tag, "_locked"},    32'(LOCKED), 0);
        chk({tag, "_err"},       32'(ERR), 0);
    endtask

    initial begin
        int lowcnt;
        RESETN = 1'b0;
        repeat (3) step();
        chk_reset("por");
        RESETN = 1'b1;
        step();
        chk("ready_after_reset", 32'(CFG_READY), 1);

        // delay 10: four flush cycles, lock one cycle after DL_VALID
        hs(10);
        chk("dl_delay_10", 32'(DL_DELAY_CLK), 10);
        chk("busy_flush", 32'(BUSY), 1);
        lowcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (!DL_RESETN) lowcnt++;
            step();
        end
        chk("flush_low_cycles", 32'(lowcnt), FL);
        chk("unlocked_in_fill", 32'(LOCKED), 0);
        DL_VALID = 1'b1;
        step();
        DL_VALID = 1'b0;
        chk("locked_after_valid", 32'(LOCKED), 1);
        repeat (3) step();
        chk("lock_holds_no_valid", 32'(LOCKED), 1);

        // clamp
        hs(120);
        chk("clamp_cur", 32'(CUR_DELAY), 100);
        chk("clamp_err", 32'(ERR), 1);
        chk("clamp_unlock", 32'(LOCKED), 0);
        relock();
        chk("clamp_relock", 32'(LOCKED), 1);
        chk("clamp_err_sticky", 32'(ERR), 1);

        // reconfigure 10 -> 30 while running
        hs(10);
        relock();
        chk("err_cleared", 32'(ERR), 0);
        hs(30);
        chk("reconf_unlock", 32'(LOCKED), 0);
        chk("reconf_busy", 32'(BUSY), 1);
        chk("reconf_dl_delay", 32'(DL_DELAY_CLK), 30);
        relock();
        chk("reconf_relock", 32'(LOCKED), 1);

        // request held through flush/fill is taken only once running
        CFG_DELAY = 7'd20;
        CFG_VALID = 1'b1;
        step();
        CFG_DELAY = 7'd40;
        chk("held_not_ready", 32'(CFG_READY), 0);
        repeat (FL + 2) step();
        chk("held_not_ready_fill", 32'(CFG_READY), 0);
        chk("held_cur_kept", 32'(CUR_DELAY), 20);
        DL_VALID = 1'b1;
        step();
        DL_VALID = 1'b0;
        chk("held_run_ready", 32'(CFG_READY), 1);
        step();
        CFG_VALID = 1'b0;
        chk("held_accepted", 32'(CUR_DELAY), 40);
        chk("held_busy", 32'(BUSY), 1);
        relock();

        // fill never completes
        hs(10);
        repeat (FL) step();
        chk("to_fill_entry", 32'(BUSY), 1);
        repeat (29) step();
        chk("to_still_fill", 32'(BUSY), 1);
        step();
`ifdef DELAY_LINE_CTRL_TIMEOUT_EN
        chk("to_err", 32'(ERR), 2);
        chk("to_idle_busy", 32'(BUSY), 0);
        chk("to_idle_ready", 32'(CFG_READY), 1);
        chk("to_idle_dlrst", 32'(DL_RESETN), 0);
        hs(10);
        repeat (FL + 1) step();
`else
        chk("noto_err", 32'(ERR), 0);
        chk("noto_busy", 32'(BUSY), 1);
        chk("noto_locked", 32'(LOCKED), 0);
`endif

        // one-cycle reset in the middle of FILL
        chk("pre_reset_fill", 32'(BUSY), 1);
        RESETN = 1'b0;
        step();
        RESETN = 1'b1;
        chk_reset("mid");
        chk("mid_ready", 32'(CFG_READY), 1);
        step();
        chk("post_reset_ready", 32'(CFG_READY), 1);

        // zero delay still flushes and fills
        hs(0);
        repeat (FL - 1) step();
        chk("d0_flush_low", 32'(DL_RESETN), 0);
        step();
        chk("d0_fill_high", 32'(DL_RESETN), 1);
        chk("d0_fill_busy", 32'(BUSY), 1);
        DL_VALID = 1'b1;
        step();
        DL_VALID = 1'b0;
        chk("d0_locked", 32'(LOCKED), 1);
        chk("d0_cur", 32'(CUR_DELAY), 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
